player_health_tracker: RTL and testbench

- Upstream feeder of the game control FSM: owns player hit points, post-hit invulnerability and the death-animation delay.
- Produces `char_alive`, which the control FSM samples during `in_process`.
- Consumes that FSM's `game_start` (hold-state pulse) and `begin_sig` (in-process level), plus collision flags from the sprite/collision logic.
- Also drives HUD hit-point display and sprite blink/death-animation selects.

---
 rtl/player_health_tracker.sv | 151 +++++++++++++++
 tb/tb_player_health_tracker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/player_health_tracker.sv
// rtl/player_health_tracker.sv - player hit points, post-hit invulnerability and death-animation delay
module player_health_tracker #(
  parameter int MAX_HP        = 3,
  parameter int HP_W          = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int DEATH_FRAMES  = 90
) (
  input  logic            Clk,
  input  logic            reset_n,
  input  logic            frame_clk,
  input  logic            game_start,
  input  logic            begin_sig,
  input  logic            hit_enemy,
  input  logic            hit_bullet,
  input  logic            fall_pit,
  output logic            char_alive,
  output logic [HP_W-1:0] hp,
  output logic            invuln,
  output logic            dying,
  output logic            hurt_pulse
);

  localparam int TMAX = (INVULN_FRAMES > DEATH_FRAMES) ? INVULN_FRAMES : DEATH_FRAMES;
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  localparam logic [HP_W-1:0] HP_FULL = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0] HP_ONE  = HP_W'(1);
  localparam logic [TW-1:0]   T_INV   = TW'(INVULN_FRAMES);
  localparam logic [TW-1:0]   T_DIE   = TW'(DEATH_FRAMES);
  localparam logic [TW-1:0]   T_ONE   = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIVE,
    S_INVULN,
    S_DYING,
    S_DEAD
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  logic frame_meta;
  logic frame_sync;
  logic frame_prev;
  logic tick;
  logic hit;
  logic pit;
  logic timer_run;
  logic fatal;

  // frame_clk is from the video clock domain; only its synchronized rising edge is used
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_meta <= 1'b0;
      frame_sync <= 1'b0;
      frame_prev <= 1'b0;
    end else begin
      frame_meta <= frame_clk;
      frame_sync <= frame_meta;
      frame_prev <= frame_sync;
    end
  end

  assign tick      = frame_sync & ~frame_prev;
  assign hit       = begin_sig & (hit_enemy | hit_bullet);
  assign pit       = begin_sig & fall_pit;
  assign timer_run = tick & begin_sig & (timer != '0);
  // a hit at one remaining hit point is treated exactly like falling into a pit
  assign fatal     = pit | (hit & (hp <= HP_ONE));

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      hp         <= HP_FULL;
      timer      <= '0;
      char_alive <= 1'b1;
      invuln     <= 1'b0;
      dying      <= 1'b0;
      hurt_pulse <= 1'b0;
    end else begin
      hurt_pulse <= 1'b0;
      if (game_start) begin
        state      <= S_ALIVE;
        hp         <= HP_FULL;
        timer      <= '0;
        char_alive <= 1'b1;
        invuln     <= 1'b0;
        dying      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_IDLE;
          end
          S_ALIVE: begin
            if (fatal) begin
              state  <= S_DYING;
              hp     <= '0;
              timer  <= T_DIE;
              dying  <= 1'b1;
              invuln <= 1'b0;
            end else if (hit) begin
              state      <= S_INVULN;
              hp         <= hp - HP_ONE;
              timer      <= T_INV;
              invuln     <= 1'b1;
              hurt_pulse <= 1'b1;
            end
          end
          // hits are ignored here so a held overlap costs a single hit point
          S_INVULN: begin
            if (pit) begin
              state  <= S_DYING;
              hp     <= '0;
              timer  <= T_DIE;
              dying  <= 1'b1;
              invuln <= 1'b0;
            end else if (timer == '0) begin
              state  <= S_ALIVE;
              invuln <= 1'b0;
            end else if (timer_run) begin
              timer <= timer - T_ONE;
            end
          end
          S_DYING: begin
            if (timer == '0) begin
              state      <= S_DEAD;
              hp         <= '0;
              dying      <= 1'b0;
              char_alive <= 1'b0;
            end else if (timer_run) begin
              timer <= timer - T_ONE;
            end
          end
          S_DEAD: begin
            state <= S_DEAD;
          end
          default: begin
            state      <= S_IDLE;
            hp         <= HP_FULL;
            timer      <= '0;
            char_alive <= 1'b1;
            invuln     <= 1'b0;
            dying      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_health_tracker.sv
// tb/tb_player_health_tracker.sv - directed self-checking bench for player_health_tracker
module tb_player_health_tracker;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       frame_clk;
  logic       game_start;
  logic       begin_sig;
  logic       hit_enemy;
  logic       hit_bullet;
  logic       fall_pit;
  logic       char_alive;
  logic [2:0] hp;
  logic       invuln;
  logic       dying;
  logic       hurt_pulse;

  int errors = 0;
  int checks = 0;
  int hurt_cnt = 0;
  int base;

  player_health_tracker #(
    .MAX_HP(3), .HP_W(3), .INVULN_FRAMES(4), .DEATH_FRAMES(3)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .frame_clk(frame_clk), .game_start(game_start),
    .begin_sig(begin_sig), .hit_enemy(hit_enemy), .hit_bullet(hit_bullet), .fall_pit(fall_pit),
    .char_alive(char_alive), .hp(hp), .invuln(invuln), .dying(dying), .hurt_pulse(hurt_pulse)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (hurt_pulse === 1'b1) hurt_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // one frame strobe; the timer update lands on the third Clk edge after the rise
  task automatic frame_tick(input int n);
    repeat (n) begin
      frame_clk = 1'b1;
      step(4);
      frame_clk = 1'b0;
      step(2);
    end
  endtask

  task automatic start_pulse();
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
  endtask

  task automatic bullet_pulse();
    hit_bullet = 1'b1;
    step(1);
    hit_bullet = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; frame_clk = 1'b0; game_start = 1'b0; begin_sig = 1'b0;
    hit_enemy = 1'b0; hit_bullet = 1'b0; fall_pit = 1'b0;
    step(2);
    check("rst_hp", hp, 3);
    check("rst_alive", char_alive, 1);
    check("rst_invuln", invuln, 0);
    check("rst_dying", dying, 0);
    check("rst_hurt", hurt_pulse, 0);
    reset_n = 1'b1;
    step(2);

    begin_sig = 1'b1; hit_enemy = 1'b1;
    step(3);
    check("idle_hit_hp", hp, 3);
    check("idle_hit_invuln", invuln, 0);
    begin_sig = 1'b0; hit_enemy = 1'b0;

    start_pulse();
    check("start_hp", hp, 3);
    check("start_alive", char_alive, 1);
    check("start_invuln", invuln, 0);

    // held enemy overlap across invulnerability windows
    base = hurt_cnt;
    begin_sig = 1'b1; hit_enemy = 1'b1;
    step(1);
    check("held_hp1", hp, 2);
    check("held_hurt_on", hurt_pulse, 1);
    check("held_invuln_on", invuln, 1);
    step(1);
    check("held_hurt_off", hurt_pulse, 0);
    frame_tick(3);
    check("held_hp_mid", hp, 2);
    check("held_invuln_mid", invuln, 1);
    frame_tick(2);
    step(150);
    check("held_hp2", hp, 1);
    check("held_invuln2", invuln, 1);
    check("held_hurt_cnt", hurt_cnt - base, 2);
    hit_enemy = 1'b0;
    frame_tick(3);
    check("held_exit_invuln", invuln, 0);
    check("held_exit_hp", hp, 1);

    // three separated hits, death animation, then DEAD held
    start_pulse();
    base = hurt_cnt;
    bullet_pulse();
    check("sep_hp2", hp, 2);
    check("sep_invuln", invuln, 1);
    frame_tick(4);
    check("sep_invuln_end", invuln, 0);
    bullet_pulse();
    check("sep_hp1", hp, 1);
    frame_tick(4);
    bullet_pulse();
    check("sep_hp0", hp, 0);
    check("sep_dying", dying, 1);
    check("sep_dying_alive", char_alive, 1);
    check("sep_dying_invuln", invuln, 0);
    step(2);
    check("sep_hurt_cnt", hurt_cnt - base, 2);
    frame_tick(2);
    check("dying_mid", dying, 1);
    check("dying_mid_alive", char_alive, 1);
    frame_tick(1);
    check("dead_alive", char_alive, 0);
    check("dead_dying", dying, 0);
    check("dead_hp", hp, 0);
    step(1000);
    check("dead_hold_alive", char_alive, 0);
    check("dead_hold_hp", hp, 0);

    // restart from DEAD, then bullet and pit together at full health
    start_pulse();
    check("restart_hp", hp, 3);
    check("restart_alive", char_alive, 1);
    base = hurt_cnt;
    hit_bullet = 1'b1; fall_pit = 1'b1;
    step(1);
    hit_bullet = 1'b0; fall_pit = 1'b0;
    check("pit_hp", hp, 0);
    check("pit_dying", dying, 1);
    check("pit_invuln", invuln, 0);
    step(2);
    check("pit_no_hurt", hurt_cnt - base, 0);

    // game_start overrides same-cycle fatal events
    game_start = 1'b1; fall_pit = 1'b1; hit_enemy = 1'b1;
    step(1);
    game_start = 1'b0; fall_pit = 1'b0; hit_enemy = 1'b0;
    check("override_hp", hp, 3);
    check("override_alive", char_alive, 1);
    check("override_dying", dying, 0);
    check("override_invuln", invuln, 0);

    // begin_sig low freezes the invulnerability timer
    bullet_pulse();
    check("freeze_hp", hp, 2);
    begin_sig = 1'b0;
    frame_tick(10);
    check("freeze_invuln", invuln, 1);
    check("freeze_hp_hold", hp, 2);
    begin_sig = 1'b1;
    frame_tick(3);
    check("resume_invuln", invuln, 1);
    frame_tick(1);
    check("resume_exit", invuln, 0);
    check("resume_hp", hp, 2);

    // asynchronous reset between clock edges while dying
    fall_pit = 1'b1;
    step(1);
    fall_pit = 1'b0;
    check("pre_rst_dying", dying, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_hp", hp, 3);
    check("async_dying", dying, 0);
    check("async_alive", char_alive, 1);
    check("async_invuln", invuln, 0);
    @(negedge Clk);
    reset_n = 1'b1;
    step(2);
    check("post_rst_hp", hp, 3);
    check("post_rst_alive", char_alive, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
